ps2_device_tx: RTL and testbench

//  Device-side PS/2 transmitter: queues scan-code bytes and serialises them onto ps2_clk/ps2_data.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_tx_fifo.sv | 59 +++++
 rtl/ps2_device_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame size, transmitter state encoding and the odd-parity helper.
// Used by ps2_device_tx and by the ps2_keyboard receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } ps2_tx_state_e;

  // Odd parity: the parity bit makes the total count of ones over data+parity odd.
  function automatic logic ps2_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte queue for the PS/2 transmitter; pop data is read combinationally from the head.
// Pushes are dropped when full and pops ignored when empty; simultaneous push+pop keeps count unchanged.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queued bytes go out as 11-bit frames; first data edge one cycle after a pop.
// in_ready drops when the queue is full; optional host inhibit (PS2_TX_INHIBIT_EN) aborts and resends frames.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int IDLE_GAP   = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
`ifdef PS2_TX_INHIBIT_EN
  input  logic                          host_inhibit,
`endif
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int HALF_MAX = (CLK_HALF > IDLE_GAP) ? CLK_HALF : IDLE_GAP;
  localparam int CW       = $clog2(HALF_MAX);
  localparam logic [3:0] STOP_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_e              state, state_n;
  logic [CW-1:0]              half_cnt, half_cnt_n;
  logic [3:0]                 bit_cnt, bit_cnt_n;
  logic [PS2_FRAME_BITS-1:0]  shifter, shifter_n;
  logic [7:0]                 tx_byte, tx_byte_n;
  logic                       resend, resend_n;
  logic                       ps2_clk_n, ps2_data_n, busy_n;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [7:0]                 fifo_dout;
  logic                       inhibit;
  logic                       abort;

`ifdef PS2_TX_INHIBIT_EN
  assign inhibit = host_inhibit;
`else
  assign inhibit = 1'b0;
`endif

  assign in_ready = resetn & ~fifo_full;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (in_valid & in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b1, ps2_parity(b), b, 1'b0};
  endfunction

  // The stop bit is never aborted: once it is on the wire the frame is already committed.
  assign abort = inhibit && (state == BIT_HI || state == BIT_LO) && (bit_cnt != STOP_BIT);

  always_comb begin
    state_n    = state;
    half_cnt_n = half_cnt;
    bit_cnt_n  = bit_cnt;
    shifter_n  = shifter;
    tx_byte_n  = tx_byte;
    resend_n   = resend;
    ps2_clk_n  = ps2_clk;
    ps2_data_n = ps2_data;
    busy_n     = busy;
    fifo_pop   = 1'b0;

    if (abort) begin
      state_n    = GAP;
      half_cnt_n = '0;
      resend_n   = 1'b1;
      ps2_clk_n  = 1'b1;
      ps2_data_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && !inhibit) begin
            fifo_pop   = 1'b1;
            tx_byte_n  = fifo_dout;
            shifter_n  = make_frame(fifo_dout);
            ps2_data_n = 1'b0;
            ps2_clk_n  = 1'b1;
            busy_n     = 1'b1;
            half_cnt_n = '0;
            bit_cnt_n  = '0;
            state_n    = BIT_HI;
          end
        end

        BIT_HI: begin
          if (half_cnt == CW'(CLK_HALF - 1)) begin
            half_cnt_n = '0;
            ps2_clk_n  = 1'b0;
            state_n    = BIT_LO;
          end else begin
            half_cnt_n = half_cnt + 1'b1;
          end
        end

        BIT_LO: begin
          if (half_cnt == CW'(CLK_HALF - 1)) begin
            half_cnt_n = '0;
            ps2_clk_n  = 1'b1;
            if (bit_cnt == STOP_BIT) begin
              ps2_data_n = 1'b1;
              state_n    = GAP;
            end else begin
              bit_cnt_n  = bit_cnt + 1'b1;
              shifter_n  = shifter >> 1;
              ps2_data_n = shifter[1];
              state_n    = BIT_HI;
            end
          end else begin
            half_cnt_n = half_cnt + 1'b1;
          end
        end

        GAP: begin
          // An asserted inhibit keeps restarting the gap, so the wait counts from its release.
          if (inhibit) begin
            half_cnt_n = '0;
          end else if (half_cnt == CW'(IDLE_GAP - 1)) begin
            half_cnt_n = '0;
            if (resend) begin
              resend_n   = 1'b0;
              shifter_n  = make_frame(tx_byte);
              ps2_data_n = 1'b0;
              bit_cnt_n  = '0;
              state_n    = BIT_HI;
            end else begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end else begin
            half_cnt_n = half_cnt + 1'b1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '1;
      tx_byte  <= '0;
      resend   <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      half_cnt <= half_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shifter  <= shifter_n;
      tx_byte  <= tx_byte_n;
      resend   <= resend_n;
      ps2_clk  <= ps2_clk_n;
      ps2_data <= ps2_data_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a frame monitor decodes the pins and checks each frame against a byte scoreboard.
module tb_ps2_device_tx;

  localparam int CLK_HALF   = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int IDLE_GAP   = 16;

  logic                          clock = 1'b0;
  logic                          resetn = 1'b0;
  logic [7:0]                    in_data = 8'h00;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic                          ps2_clk;
  logic                          ps2_data;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
`ifdef PS2_TX_INHIBIT_EN
  logic                          host_inhibit = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   f0_seen = 0;
  int   frames_seen = 0;
  logic gap_check_en = 1'b0;
  logic mon_flush = 1'b0;
  logic saw_blocked = 1'b0;

  ps2_device_tx #(
    .CLK_HALF   (CLK_HALF),
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDLE_GAP   (IDLE_GAP)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
`ifdef PS2_TX_INHIBIT_EN
    .host_inhibit (host_inhibit),
`endif
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity by counting ones: bit is 1 when the data has an even number of ones.
  function automatic logic odd_par(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return (n % 2) == 0;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input logic p);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 4000) begin
      if (!saw_blocked) check("count_when_blocked", 32'(fifo_count), FIFO_DEPTH);
      saw_blocked = 1'b1;
      @(negedge clock);
      waited++;
    end
    check("in_ready_before_accept", 32'(in_ready), 1);
    if (in_ready) exp_q.push_back('{b: b, p: p});
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_falls(input int n);
    int   seen = 0;
    int   guard = 0;
    logic prev;
    prev = ps2_clk;
    while (seen < n && guard < 4000) begin
      @(negedge clock);
      guard++;
      if (prev && !ps2_clk) seen++;
      prev = ps2_clk;
    end
    check("falls_seen", seen, n);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 8000) begin
      @(negedge clock);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy_low", 32'(busy), 0);
  endtask

  // Frame monitor: receiver view of the pins, sampling data on each ps2_clk fall.
  initial begin : monitor
    logic       prev_clk;
    logic       prev_data;
    logic [10:0] bits;
    int         nbits;
    int         rise_cyc;
    logic       await_rise;
    exp_t       e;
    prev_clk   = 1'b1;
    prev_data  = 1'b1;
    bits       = '0;
    nbits      = 0;
    rise_cyc   = -1;
    await_rise = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn || mon_flush) begin
        nbits      = 0;
        rise_cyc   = -1;
        await_rise = 1'b0;
      end else begin
        if (!prev_clk && !ps2_clk) check("data_stable_clk_low", 32'(ps2_data), 32'(prev_data));
        if (!prev_clk && ps2_clk && await_rise) begin
          rise_cyc   = cyc;
          await_rise = 1'b0;
        end
        if (prev_data && !ps2_data && ps2_clk && nbits == 0) begin
          // Lines-high interval covers the gap plus the single idle cycle that pops the next byte.
          if (gap_check_en && rise_cyc >= 0) check("inter_frame_gap", cyc - rise_cyc, IDLE_GAP + 1);
          rise_cyc = -1;
        end
        if (prev_clk && !ps2_clk) begin
          bits[nbits] = ps2_data;
          nbits++;
          if (nbits == 11) begin
            nbits      = 0;
            await_rise = 1'b1;
            frames_seen++;
            if (bits[8:1] == 8'hF0) f0_seen++;
            check("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("start_bit", 32'(bits[0]), 0);
              check("data_byte", 32'(bits[8:1]), 32'(e.b));
              check("parity_bit", 32'(bits[9]), 32'(e.p));
              check("stop_bit", 32'(bits[10]), 1);
            end
          end
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ps2_clk", 32'(ps2_clk), 1);
    check("rst_ps2_data", 32'(ps2_data), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_in_ready", 32'(in_ready), 1);

    // Test 1: single byte, latency and first-edge timing.
    send_byte(8'h1C, 1'b0);
    check("t1_count_after_push", 32'(fifo_count), 1);
    check("t1_data_before_pop", 32'(ps2_data), 1);
    @(negedge clock);
    check("t1_start_bit_driven", 32'(ps2_data), 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_count_after_pop", 32'(fifo_count), 0);
    repeat (CLK_HALF - 1) @(negedge clock);
    check("t1_clk_high_phase", 32'(ps2_clk), 1);
    @(negedge clock);
    check("t1_first_fall", 32'(ps2_clk), 0);
    wait_drain();

    // Test 2: back-to-back frames with exact gaps, F0 seen once.
    send_byte(8'h1C, odd_par(8'h1C));
    repeat (2) @(negedge clock);
    gap_check_en = 1'b1;
    send_byte(8'hF0, odd_par(8'hF0));
    send_byte(8'h1C, odd_par(8'h1C));
    wait_drain();
    gap_check_en = 1'b0;
    check("t2_f0_once", f0_seen, 1);

    // Test 3: sixteen bytes pushed while sending; queue fills and back-pressures.
    send_byte(8'h00, odd_par(8'h00));
    repeat (2) @(negedge clock);
    gap_check_en = 1'b1;
    for (int i = 1; i < 16; i++) send_byte(8'(i), odd_par(8'(i)));
    check("t3_blocked_when_full", 32'(saw_blocked), 1);
    wait_drain();
    gap_check_en = 1'b0;

    // Test 4: parity corner cases with fixed expected parity.
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h80, 1'b0);
    wait_drain();

    // Test 5: reset mid-frame, then a clean frame.
    send_byte(8'h55, odd_par(8'h55));
    send_byte(8'h66, odd_par(8'h66));
    wait_falls(5);
    check("t5_pre_reset_count", 32'(fifo_count), 1);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("t5_rst_ps2_clk", 32'(ps2_clk), 1);
    check("t5_rst_ps2_data", 32'(ps2_data), 1);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_fifo_count", 32'(fifo_count), 0);
    check("t5_rst_in_ready", 32'(in_ready), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    send_byte(8'h1B, odd_par(8'h1B));
    wait_drain();

`ifdef PS2_TX_INHIBIT_EN
    // Test 6: inhibit during bit 4 aborts; frame resent once after release plus IDLE_GAP.
    begin
      int frames_before;
      frames_before = frames_seen;
      send_byte(8'h3C, odd_par(8'h3C));
      wait_falls(4);
      host_inhibit = 1'b1;
      mon_flush    = 1'b1;
      @(negedge clock);
      check("t6_clk_released", 32'(ps2_clk), 1);
      check("t6_data_released", 32'(ps2_data), 1);
      repeat (20) @(negedge clock);
      check("t6_held_high", 32'(ps2_data), 1);
      host_inhibit = 1'b0;
      mon_flush    = 1'b0;
      repeat (IDLE_GAP - 1) @(negedge clock);
      check("t6_no_early_resend", 32'(ps2_data), 1);
      @(negedge clock);
      check("t6_resend_start", 32'(ps2_data), 0);
      wait_drain();
      check("t6_received_once", frames_seen - frames_before, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
